// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master data RAM arbiter.
package mem_arbiter_pkg;

  // Master port indices, also used as the tag "port" field.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Supported RAM read latency range.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;

  // Read response tag carried alongside an in-flight RAM read.
  typedef struct packed {
    logic v;
    logic port;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_resp_tag_pipe.sv
// LAT-deep shift register of read tags; the last stage lines up with ram_rdata.
module resp_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [LAT-1:0] stg;

  // Shift tags one stage per cycle; reset drops every in-flight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      stg <= '0;
    end else begin
      stg[0] <= tag_in;
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

  assign tag_out = stg[LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous data RAM between two masters.
// Reads are tagged with the issuing master and routed back LAT cycles later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LAT = 1  // RAM read latency, LAT_MIN..LAT_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_oe,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_oe,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_valid,
  output logic        m1_ready,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_oe,
  output logic [3:0]  ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic        last;
  logic [1:0]  pend;
  logic [31:0] hold0, hold1;
  logic        req0, req1, gnt0, gnt1, rsp0, rsp1;
  tag_t        tag_in, tag_out;

  assign req0 = |m0_oe;
  assign req1 = |m1_oe;

  // Ready looks only at the other master's request, never the own one, so the
  // processor's stall logic cannot form a combinational loop through here.
  always_comb begin
    m0_ready = !rst & !pend[M0] & !(req1 & !pend[M1] & (last == M0));
    m1_ready = !rst & !pend[M1] & !(req0 & !pend[M0] & (last == M1));
  end

  assign gnt0 = req0 & m0_ready;
  assign gnt1 = req1 & m1_ready;

  // Route the granted master to the RAM; idle cycles park address/data on m0.
  always_comb begin
    ram_addr  = m0_addr;
    ram_wdata = m0_wdata;
    ram_oe    = '0;
    ram_we    = '0;
    if (gnt1) begin
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_oe    = m1_oe;
      ram_we    = m1_we;
    end else if (gnt0) begin
      ram_oe = m0_oe;
      ram_we = m0_we;
    end
  end

  // Only reads get a tag; writes complete silently.
  always_comb begin
    tag_in.v    = (gnt0 & ~(|m0_we)) | (gnt1 & ~(|m1_we));
    tag_in.port = gnt1 ? M1 : M0;
  end

  resp_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign rsp0 = !rst & tag_out.v & (tag_out.port == M0);
  assign rsp1 = !rst & tag_out.v & (tag_out.port == M1);

  // Response data passes straight through in the valid cycle, else the held word.
  always_comb begin
    m0_valid = rsp0;
    m1_valid = rsp1;
    m0_rdata = rsp0 ? ram_rdata : hold0;
    m1_rdata = rsp1 ? ram_rdata : hold1;
  end

  // Round-robin pointer, outstanding-read flags and held read words.
  always_ff @(posedge clk) begin
    if (rst) begin
      last  <= M1;
      pend  <= '0;
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (gnt0)      last <= M0;
      else if (gnt1) last <= M1;

      if (gnt0 & ~(|m0_we)) pend[M0] <= 1'b1;
      else if (rsp0)        pend[M0] <= 1'b0;
      if (gnt1 & ~(|m1_we)) pend[M1] <= 1'b1;
      else if (rsp1)        pend[M1] <= 1'b0;

      if (rsp0) hold0 <= ram_rdata;
      if (rsp1) hold1 <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: three arbiters (LAT 1, 3, 2) share master stimulus, each
// with its own behavioural byte-lane RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_oe, m0_we, m1_oe, m1_we;

  logic        m0_ready [3];
  logic        m0_valid [3];
  logic        m1_ready [3];
  logic        m1_valid [3];
  logic [31:0] m0_rdata [3];
  logic [31:0] m1_rdata [3];
  logic [31:0] ram_addr [3];
  logic [31:0] ram_wdata[3];
  logic [31:0] ram_rdata[3];
  logic [3:0]  ram_oe   [3];
  logic [3:0]  ram_we   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 2;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 2;
    logic [31:0] mem [64];
    logic [31:0] rp  [L];

    mem_arbiter #(.LAT(L)) u_dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m0_oe(m0_oe), .m0_we(m0_we), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata[g]), .m0_valid(m0_valid[g]), .m0_ready(m0_ready[g]),
      .m1_addr(m1_addr), .m1_oe(m1_oe), .m1_we(m1_we), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata[g]), .m1_valid(m1_valid[g]), .m1_ready(m1_ready[g]),
      .ram_addr(ram_addr[g]), .ram_oe(ram_oe[g]), .ram_we(ram_we[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
    );

    always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
        if (ram_we[g][b]) mem[ram_addr[g][7:2]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
      if (|ram_oe[g]) rp[0] <= mem[ram_addr[g][7:2]];
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    end

    assign ram_rdata[g] = rp[L-1];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_oe = '0; m0_we = '0;
    m1_oe = '0; m1_we = '0;
  endtask

  task automatic drain(input int n);
    idle();
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_oe = 4'hF; m0_we = '0; m0_addr = 32'h30; m0_wdata = '0;
    m1_oe = 4'hF; m1_we = '0; m1_addr = 32'h20; m1_wdata = '0;
    repeat (2) begin
      tick(); #1;
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({m0_ready[g], m1_ready[g], m0_valid[g], m1_valid[g], ram_oe[g], ram_we[g]} !== 12'h0) begin
          errors++;
          $display("FAIL reset_quiet inst%0d got r0=%b r1=%b v0=%b v1=%b oe=%h we=%h want all 0",
                   g, m0_ready[g], m1_ready[g], m0_valid[g], m1_valid[g], ram_oe[g], ram_we[g]);
        end
      end
    end
    tick();
    rst = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (m0_ready[g] !== 1'b1 || m1_ready[g] !== 1'b0) begin
        errors++;
        $display("FAIL first_contention inst%0d got r0=%b r1=%b want r0=1 r1=0", g, m0_ready[g], m1_ready[g]);
      end
      checks++;
      if (ram_addr[g] !== 32'h30 || ram_oe[g] !== 4'hF) begin
        errors++;
        $display("FAIL first_grant_ram inst%0d got addr=%h oe=%h want 30/f", g, ram_addr[g], ram_oe[g]);
      end
    end
    tick();
    drain(5);
  endtask

  task automatic test_single_read();
    m1_oe = 4'hF; m1_we = 4'hF; m1_addr = 32'h100; m1_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if (m1_ready[0] !== 1'b1 || ram_we[0] !== 4'hF || ram_wdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL preload_write got r1=%b we=%h wd=%h want 1/f/deadbeef", m1_ready[0], ram_we[0], ram_wdata[0]);
    end
    tick();
    idle();
    m0_oe = 4'hF; m0_addr = 32'h100;
    #1;
    checks++;
    if (m0_ready[0] !== 1'b1 || ram_addr[0] !== 32'h100 || ram_oe[0] !== 4'hF || ram_we[0] !== 4'h0) begin
      errors++;
      $display("FAIL read_accept got r0=%b addr=%h oe=%h we=%h want 1/100/f/0", m0_ready[0], ram_addr[0], ram_oe[0], ram_we[0]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m0_valid[0] !== 1'b1 || m0_rdata[0] !== 32'hDEADBEEF || m1_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL read_resp got v0=%b d=%h v1=%b want 1/deadbeef/0", m0_valid[0], m0_rdata[0], m1_valid[0]);
    end
    tick();
    #1;
    checks++;
    if (m0_valid[0] !== 1'b0 || m0_rdata[0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_hold got v0=%b d=%h want 0/deadbeef", m0_valid[0], m0_rdata[0]);
    end
    drain(4);
  endtask

  task automatic test_contention();
    // A lone m1 grant moves the pointer so m0 wins the first contended cycle.
    m1_oe = 4'hF; m1_we = 4'hF; m1_addr = 32'h30; m1_wdata = 32'h0;
    tick();
    m0_oe = 4'hF; m0_we = 4'hF; m0_addr = 32'h10; m0_wdata = 32'hA0;
    m1_oe = 4'hF; m1_we = 4'hF; m1_addr = 32'h20; m1_wdata = 32'hB0;
    for (int c = 0; c < 4; c++) begin
      #1;
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ram_addr[g] !== ((c % 2 == 0) ? 32'h10 : 32'h20) || m0_ready[g] !== (c % 2 == 0)) begin
          errors++;
          $display("FAIL contention c%0d inst%0d got addr=%h r0=%b want addr=%h r0=%b",
                   c, g, ram_addr[g], m0_ready[g], (c % 2 == 0) ? 32'h10 : 32'h20, (c % 2 == 0));
        end
      end
      tick();
    end
    drain(2);
  endtask

  task automatic test_ordering();
    m1_oe = 4'hF; m1_we = 4'hF; m1_addr = 32'h40; m1_wdata = 32'h55AA55AA;
    #1;
    checks++;
    if (m1_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL order_write got r1=%b want 1", m1_ready[0]);
    end
    tick();
    idle();
    m0_oe = 4'hF; m0_addr = 32'h40;
    #1;
    checks++;
    if (m0_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL order_read_accept got r0=%b want 1", m0_ready[0]);
    end
    tick();
    idle();
    for (int k = 1; k <= 3; k++) begin
      #1;
      for (int g = 0; g < 3; g++) begin
        if (lat_of(g) == k) begin
          checks++;
          if (m0_valid[g] !== 1'b1 || m0_rdata[g] !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL order_resp inst%0d got v0=%b d=%h want 1/55aa55aa", g, m0_valid[g], m0_rdata[g]);
          end
        end
      end
      tick();
    end
    drain(3);
  endtask

  task automatic test_lat3_block();
    m0_oe = 4'hF; m0_we = '0; m0_addr = 32'h40;
    #1;
    checks++;
    if (m0_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL lat3_first got r0=%b want 1", m0_ready[1]);
    end
    tick();
    for (int k = 1; k <= 3; k++) begin
      m1_oe = 4'hF; m1_we = 4'hF; m1_addr = 32'h80; m1_wdata = {8{4'(k)}};
      #1;
      checks++;
      if (m0_ready[1] !== 1'b0 || m1_ready[1] !== 1'b1 || ram_addr[1] !== 32'h80) begin
        errors++;
        $display("FAIL lat3_block t+%0d got r0=%b r1=%b addr=%h want 0/1/80", k, m0_ready[1], m1_ready[1], ram_addr[1]);
      end
      checks++;
      if (m0_valid[1] !== (k == 3) || (k == 3 && m0_rdata[1] !== 32'h55AA55AA)) begin
        errors++;
        $display("FAIL lat3_valid t+%0d got v0=%b d=%h want v0=%b d=55aa55aa", k, m0_valid[1], m0_rdata[1], (k == 3));
      end
      tick();
    end
    m1_oe = '0; m1_we = '0;
    #1;
    checks++;
    if (m0_ready[1] !== 1'b1 || ram_addr[1] !== 32'h40) begin
      errors++;
      $display("FAIL lat3_regrant got r0=%b addr=%h want 1/40", m0_ready[1], ram_addr[1]);
    end
    tick();
    drain(5);
  endtask

  task automatic test_reset_mid_read();
    m1_oe = 4'hF; m1_we = 4'hF; m1_addr = 32'h80; m1_wdata = 32'h0BADF00D;
    tick();
    m1_we = '0;
    #1;
    checks++;
    if (m1_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_accept got r1=%b want 1", m1_ready[2]);
    end
    tick();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (m1_valid[2] !== 1'b0 || m1_ready[2] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_during got v1=%b r1=%b want 0/0", m1_valid[2], m1_ready[2]);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (m1_valid[2] !== 1'b0 || m1_rdata[2] !== 32'h0 || m0_rdata[2] !== 32'h0) begin
      errors++;
      $display("FAIL midrst_dropped got v1=%b d1=%h d0=%h want 0/0/0", m1_valid[2], m1_rdata[2], m0_rdata[2]);
    end
    m1_oe = 4'hF; m1_we = '0; m1_addr = 32'h80;
    #1;
    checks++;
    if (m1_ready[2] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reaccept got r1=%b want 1", m1_ready[2]);
    end
    tick();
    idle();
    #1;
    checks++;
    if (m1_valid[2] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_early got v1=%b want 0", m1_valid[2]);
    end
    tick();
    #1;
    checks++;
    if (m1_valid[2] !== 1'b1 || m1_rdata[2] !== 32'h0BADF00D) begin
      errors++;
      $display("FAIL midrst_resp got v1=%b d=%h want 1/0badf00d", m1_valid[2], m1_rdata[2]);
    end
    drain(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_ordering();
    test_lat3_block();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
